adder: RTL and testbench
========================

Name: adder

Overview:
- Registered ripple-carry adder, WIDTH bits wide; the default WIDTH=1 is a single-bit full adder.
- Computes a + b + cin and produces sum and cout, registered with a one-cycle latency.
- Serves as the arithmetic building block for the processor datapath (ALU add path, PC increment).
- Built from a chain of 1-bit full-adder cells.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b, cin for capture this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in to bit 0.
- out_valid  output  1  high for one cycle when sum and cout hold a new result.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of the MSB.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, sum=0, cout=0, out_valid=0, forced immediately without waiting for clk. Deassertion is synchronised by the caller; the first capture is possible on the first rising edge with rst_n=1.
- Combinational core, per bit i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = cin; cout = c[WIDTH].
- Capture: on a rising clk edge with in_valid=1, sum/cout register the core result and out_valid goes to 1. Latency is exactly 1 cycle.
- Idle: on a rising edge with in_valid=0, out_valid goes to 0 and sum/cout hold their previous values.
- Back-to-back: in_valid high on consecutive cycles gives one result per cycle; no stalls, no backpressure.
- Wrap-around: all-ones + all-ones + 1 gives sum = all-ones, cout = 1. All-ones + 0 + 1 gives sum = 0, cout = 1.
- X/Z on inputs while in_valid=0 must not disturb the registered outputs.
- Reset mid-operation: asserting rst_n in the same cycle as in_valid discards the operation; outputs remain at their reset values.
- No internal state other than the output registers.

Optional Feature:
- Macro: ADDER_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit). It is registered alongside sum and equals c[WIDTH] ^ c[WIDTH-1] (two's-complement signed overflow). For WIDTH=1, ovf = cout ^ cin. Reset value 0. It holds its value when in_valid=0.
- Undefined: the ovf port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - ADDER_MAX_WIDTH = 32 constant.
  - Typedef for the {cout, sum} result pair, used by the datapath.
- One sub-module, full_adder_cell: 1-bit combinational full adder (a, b, ci -> s, co).
  - Instantiated WIDTH times with a generate loop.
  - Carry chain wired cell to cell.
- The top level contains only the generate chain, the output registers and the optional overflow logic.

Test Plan:
- Exhaustive 1-bit truth table, WIDTH=1, in_valid=1, one vector per cycle, each result checked one cycle later:
  - (0,0,0)->S0 C0; (0,0,1)->S1 C0; (0,1,0)->S1 C0; (0,1,1)->S0 C1
  - (1,0,0)->S1 C0; (1,0,1)->S0 C1; (1,1,0)->S0 C1; (1,1,1)->S1 C1
- Async reset: load a=1,b=1,cin=1 (sum=1,cout=1). Drop rst_n mid-cycle -> sum=0, cout=0, out_valid=0 before the next clk edge.
- Hold: capture (1,0,0) -> sum=1. Then in_valid=0 with a=1,b=1,cin=1 for 3 cycles -> sum stays 1, cout 0, out_valid 0.
- WIDTH=8 wrap: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0; with ADDER_OVERFLOW_EN, ovf=1.
- WIDTH=8 back-to-back: 0x10+0x20+0, 0xF0+0x20+0, 0x01+0x01+1 on consecutive cycles -> 0x30/C0, 0x10/C1, 0x03/C0. out_valid high for 3 consecutive cycles.
- Reset coincident with in_valid=1 (a=1,b=1) -> no result, out_valid stays 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, result type and bit-level helpers for the adder datapath block.
package adder_pkg;

    localparam int ADDER_MAX_WIDTH = 32;

    // {cout, sum} pair as consumed by the processor datapath; sum is zero-extended to the max width.
    typedef struct packed {
        logic                       cout;
        logic [ADDER_MAX_WIDTH-1:0] sum;
    } adder_result_t;

    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder: the repeating cell of the ripple-carry chain.
module full_adder_cell
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = xor3(a, b, ci);
    assign co = maj3(a, b, ci);

endmodule

// File: rtl/adder.sv
// Registered WIDTH-bit ripple-carry adder (one-cycle latency) built from full_adder_cell.
// Optional macro ADDER_OVERFLOW_EN adds a registered two's-complement overflow output ovf.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_core_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             valid_d;
    logic             valid_q;
`ifdef ADDER_OVERFLOW_EN
    logic             ovf_d;
    logic             ovf_q;
`endif

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry_s[i]),
            .s  (sum_core_s[i]),
            .co (carry_s[i+1])
        );
    end

    // Next-state: capture the chain result when qualified, otherwise hold so idle inputs cannot leak in.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
`ifdef ADDER_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            sum_d   = sum_core_s;
            cout_d  = carry_s[WIDTH];
            valid_d = 1'b1;
`ifdef ADDER_OVERFLOW_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_d   = carry_s[WIDTH] ^ carry_s[WIDTH-1];
`endif
        end else begin
            sum_d   = sum_q;
            cout_d  = cout_q;
            valid_d = 1'b0;
`ifdef ADDER_OVERFLOW_EN
            ovf_d   = ovf_q;
`endif
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef ADDER_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
`ifdef ADDER_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: a WIDTH=1 and a WIDTH=8 instance checked against an arithmetic model.
module tb_adder;

    typedef struct packed {
        logic       ovf;
        logic       cout;
        logic [7:0] sum;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, a1, b1, c1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic       ov1, s1, co1;
    logic       ov8, co8;
    logic [7:0] s8;
    logic       ovf1, ovf8;

    int   checks   = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q8[$];
    exp_t e1, e8;
    logic [2:0] run8;

    always #5 clk = ~clk;

    adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef ADDER_OVERFLOW_EN
        , .ovf(ovf8)
`endif
    );

`ifndef ADDER_OVERFLOW_EN
    assign ovf1 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    // Reference: plain integer sum for sum/cout, signed-range test for overflow.
    function automatic exp_t model(input int w, input int a, input int b, input int c);
        exp_t e;
        int   total, half, sa, sb, s;
        total  = a + b + c;
        e.sum  = 8'(total % (1 << w));
        e.cout = (total >= (1 << w));
        half   = 1 << (w - 1);
        sa     = (a >= half) ? a - 2 * half : a;
        sb     = (b >= half) ? b - 2 * half : b;
        s      = sa + sb + c;
        e.ovf  = (s > half - 1) || (s < -half);
`ifndef ADDER_OVERFLOW_EN
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set1(input logic v, input int a, input int b, input int c);
        v1 = v; a1 = 1'(a); b1 = 1'(b); c1 = 1'(c);
        if (v) q1.push_back(model(1, a, b, c));
    endtask

    task automatic set8(input logic v, input int a, input int b, input int c);
        v8 = v; a8 = 8'(a); b8 = 8'(b); c8 = 1'(c);
        if (v) q8.push_back(model(8, a, b, c));
    endtask

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (ov1) begin
            if (q1.size() == 0) begin
                check("w1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("w1_result", {22'd0, ovf1, co1, 7'd0, s1}, 32'(e1));
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (ov8) begin
            if (q8.size() == 0) begin
                check("w8_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("w8_result", {22'd0, ovf8, co8, s8}, 32'(e8));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set1(1'b0, 0, 0, 0);
        set8(1'b0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_w1", {28'd0, ov1, s1, co1, ovf1}, 32'd0);
        check("rst_w8", {20'd0, ov8, s8, co8, ovf8}, 32'd0);
        rst_n = 1'b1;

        // Exhaustive 1-bit truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set1(1'b1, (i >> 2) & 1, (i >> 1) & 1, i & 1);
        end
        @(posedge clk); #1;
        set1(1'b0, 0, 0, 0);

        // Hold with garbage on the idle inputs.
        @(posedge clk); #1;
        set1(1'b1, 1, 0, 0);
        @(posedge clk); #1;
        v1 = 1'b0; a1 = 1'bx; b1 = 1'b1; c1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("hold_w1", {29'd0, ov1, s1, co1}, 32'b010);
        end

        // Asynchronous reset mid-cycle.
        @(posedge clk); #1;
        set1(1'b1, 1, 1, 1);
        @(posedge clk); #1;
        set1(1'b0, 0, 0, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_w1", {28'd0, ov1, s1, co1, ovf1}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset coincident with a qualified operation.
        @(posedge clk); #1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_coinc_w1", {29'd0, ov1, s1, co1}, 32'd0);
        check("rst_coinc_w8", {22'd0, ov8, s8, co8}, 32'd0);
        v1 = 1'b0; v8 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_coinc_after", {30'd0, ov1, ov8}, 32'd0);

        // 8-bit wrap-around and signed overflow.
        set8(1'b1, 8'hFF, 8'h00, 1);
        @(posedge clk); #1;
        set8(1'b1, 8'h7F, 8'h01, 0);
        @(posedge clk); #1;
        set8(1'b1, 8'hFF, 8'hFF, 1);
        @(posedge clk); #1;
        set8(1'b0, 0, 0, 0);

        // 8-bit back-to-back stream.
        @(posedge clk); #1;
        set8(1'b1, 8'h10, 8'h20, 0);
        @(posedge clk); #1;
        run8[0] = ov8;
        set8(1'b1, 8'hF0, 8'h20, 0);
        @(posedge clk); #1;
        run8[1] = ov8;
        set8(1'b1, 8'h01, 8'h01, 1);
        @(posedge clk); #1;
        run8[2] = ov8;
        set8(1'b0, 0, 0, 0);
        check("b2b_valid_run", 32'(run8), 32'd7);
        @(posedge clk); #1;
        check("b2b_valid_drop", 32'(ov8), 32'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            set1(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1));
            set8(($urandom_range(0, 3) != 0), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1));
        end
        @(posedge clk); #1;
        set1(1'b0, 0, 0, 0);
        set8(1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("w1_queue_drained", 32'(q1.size()), 32'd0);
        check("w8_queue_drained", 32'(q8.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
